// File: rtl/mips_wb_arbiter_pkg.sv
// Shared constants and types for the MIPS writeback path.
// The arbiter, its bus interface and the testbench all import this package.
package mips_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int XLEN       = 32;
  localparam int NUM_WB_REQ = 3;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [XLEN-1:0]       data;
  } wb_req_t;

endpackage

// File: rtl/mips_wb_arbiter_if.sv
// Bundle of writeback requester, reservation and regfile-write signals.
// The "slave" modport is the arbiter; "master" is the execute/issue side.
interface mips_wb_arbiter_if
  import mips_pkg::*;
#(
  parameter int NUM_REQ = NUM_WB_REQ,
  parameter int ADDR_W  = REG_ADDR_W,
  parameter int DATA_W  = XLEN
);

  logic [NUM_REQ-1:0]             req_valid_i;
  logic [NUM_REQ-1:0]             req_ready_o;
  logic [NUM_REQ-1:0][ADDR_W-1:0] req_addr_i;
  logic [NUM_REQ-1:0][DATA_W-1:0] req_data_i;
  logic                           rsv_valid_i;
  logic [ADDR_W-1:0]              rsv_addr_i;
  logic [(2**ADDR_W)-1:0]         busy_o;
  logic                           rf_we_o;
  logic [ADDR_W-1:0]              rf_waddr_o;
  logic [DATA_W-1:0]              rf_wdata_o;
  logic                           err_o;

  modport slave (
    input  req_valid_i, req_addr_i, req_data_i, rsv_valid_i, rsv_addr_i,
    output req_ready_o, busy_o, rf_we_o, rf_waddr_o, rf_wdata_o, err_o
  );

  modport master (
    output req_valid_i, req_addr_i, req_data_i, rsv_valid_i, rsv_addr_i,
    input  req_ready_o, busy_o, rf_we_o, rf_waddr_o, rf_wdata_o, err_o
  );

endinterface

// File: rtl/mips_wb_arbiter_rr.sv
// Round-robin arbiter: one-hot grant to the first requester at or after the
// pointer; the pointer moves just past the winner whenever a grant is made.
module mips_rr_arbiter
  import mips_pkg::*;
#(
  parameter int N = NUM_WB_REQ
) (
  input  logic         clk_i,
  input  logic         nrst_i,
  input  logic [N-1:0] i_req,
  output logic [N-1:0] o_gnt
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] r_ptr;
  logic [PW-1:0] w_ptrNext;
  logic [N-1:0]  w_gnt;
  logic          w_found;

  // Scan ptr, ptr+1, ... with wraparound; grants are forced off during reset.
  always_comb begin
    w_gnt     = '0;
    w_ptrNext = r_ptr;
    w_found   = 1'b0;
    for (int k = 0; k < N; k++) begin
      int idx;
      idx = int'(r_ptr) + k;
      if (idx >= N) idx = idx - N;
      if (!w_found && i_req[idx]) begin
        w_found    = 1'b1;
        w_gnt[idx] = 1'b1;
        w_ptrNext  = (idx == N - 1) ? '0 : PW'(idx + 1);
      end
    end
    if (!nrst_i) w_gnt = '0;
  end

  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i)    r_ptr <= '0;
    else if (w_found) r_ptr <= w_ptrNext;
  end

  assign o_gnt = w_gnt;

endmodule

// File: rtl/mips_wb_arbiter.sv
// Writeback arbiter: round-robins the regfile write port between requesters,
// registers the winning write, and tracks per-register pending writes.
module mips_wb_arbiter
  import mips_pkg::*;
#(
  parameter int NUM_REQ = NUM_WB_REQ,
  parameter int ADDR_W  = REG_ADDR_W,
  parameter int DATA_W  = XLEN
) (
  input  logic             clk_i,
  input  logic             nrst_i,
  mips_wb_arbiter_if.slave bus
);

  localparam int NREG = 2 ** ADDR_W;

  logic [NUM_REQ-1:0] w_gnt;
  logic               w_acc;
  logic               w_wr;
  logic [ADDR_W-1:0]  w_accAddr;
  logic [DATA_W-1:0]  w_accData;
  logic [NREG-1:0]    w_set;
  logic [NREG-1:0]    w_clr;
  logic [NREG-1:0]    w_busyNext;
  logic               w_errRsv;
  logic               w_errWr;

  logic               r_we;
  logic [ADDR_W-1:0]  r_waddr;
  logic [DATA_W-1:0]  r_wdata;
  logic [NREG-1:0]    r_busy;
  logic               r_err;

  mips_rr_arbiter #(.N(NUM_REQ)) u_rr (
    .clk_i  (clk_i),
    .nrst_i (nrst_i),
    .i_req  (bus.req_valid_i),
    .o_gnt  (w_gnt)
  );

  always_comb begin
    w_acc     = |w_gnt;
    w_accAddr = '0;
    w_accData = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_gnt[i]) begin
        w_accAddr = bus.req_addr_i[i];
        w_accData = bus.req_data_i[i];
      end
    end
    w_wr = w_acc && (w_accAddr != '0);
  end

  // Register 0 is never tracked; a reservation beats a same-cycle clear.
  always_comb begin
    w_set      = '0;
    w_clr      = '0;
    w_busyNext = '0;
    for (int r = 1; r < NREG; r++) begin
      w_set[r]      = bus.rsv_valid_i && (bus.rsv_addr_i == ADDR_W'(r));
      w_clr[r]      = w_wr && (w_accAddr == ADDR_W'(r));
      w_busyNext[r] = w_set[r] | (r_busy[r] & ~w_clr[r]);
    end
    w_errRsv = bus.rsv_valid_i && (bus.rsv_addr_i != '0) &&
               r_busy[bus.rsv_addr_i] && !w_clr[bus.rsv_addr_i];
    w_errWr  = w_wr && !r_busy[w_accAddr];
  end

  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      r_we    <= 1'b0;
      r_waddr <= '0;
      r_wdata <= '0;
      r_busy  <= '0;
      r_err   <= 1'b0;
    end else begin
      r_we   <= w_wr;
      r_busy <= w_busyNext;
      if (w_wr) begin
        r_waddr <= w_accAddr;
        r_wdata <= w_accData;
      end
      if (w_errRsv || w_errWr) r_err <= 1'b1;
    end
  end

  assign bus.req_ready_o = w_gnt;
  assign bus.busy_o      = r_busy;
  assign bus.rf_we_o     = r_we;
  assign bus.rf_waddr_o  = r_waddr;
  assign bus.rf_wdata_o  = r_wdata;
  assign bus.err_o       = r_err;

endmodule
